// File: rtl/rx_serial_7e2_pkg.sv
// Shared definitions for the 7E2 serial receiver: state codes, frame constants and parity helper.
// The RX_PARITY_CHECK_EN build option is consumed in rx_serial_7e2.sv, not here.
package rx_serial_7e2_pkg;

  localparam int BAUD_DIV_PADRAO = 434;
  localparam int N_DADOS         = 7;

  // Encoding is visible on db_estado for the hexa7seg debug display
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_DADOS    = 4'd2,
    S_PARIDADE = 4'd3,
    S_STOP1    = 4'd4,
    S_STOP2    = 4'd5,
    S_ARMAZENA = 4'd6,
    S_ERRO     = 4'd7
  } estado_t;

  // Returns 0 when data plus parity bit hold an even number of ones
  function automatic logic paridade_calc(input logic [N_DADOS-1:0] dados, input logic pbit);
    return ^{dados, pbit};
  endfunction

endpackage

// File: rtl/rx_serial_7e2_baud_tick.sv
// Mod-BAUD_DIV bit-time counter with synchronous clear.
// Flags the half-bit point (start-bit centre) and the full-bit point (mid-bit sampling).
module rx_baud_tick #(
  parameter int BAUD_DIV = 434
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_limpa,
  output logic o_tick_meio,
  output logic o_tick_fim
);

  localparam int W = $clog2(BAUD_DIV);

  logic [W-1:0] r_cont;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_cont <= '0;
    end else if (i_limpa || (r_cont == W'(BAUD_DIV - 1))) begin
      r_cont <= '0;
    end else begin
      r_cont <= r_cont + 1'b1;
    end
  end

  assign o_tick_meio = (r_cont == W'(BAUD_DIV / 2 - 1));
  assign o_tick_fim  = (r_cont == W'(BAUD_DIV - 1));

endmodule

// File: rtl/rx_serial_7e2.sv
// 7E2 asynchronous serial receiver for the sonar host link (7 data bits LSB first, even parity, 2 stops).
// Define RX_PARITY_CHECK_EN to reject frames with bad parity; otherwise parity is only reported.
module rx_serial_7e2
  import rx_serial_7e2_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dado_serial,
  input  logic                limpa,
  output logic [N_DADOS-1:0]  dado_recebido,
  output logic                pronto,
  output logic                tem_dado,
  output logic                paridade_ok,
  output logic                erro_stop,
  output logic [3:0]          db_estado
);

  estado_t            r_estado, w_prox;
  logic [1:0]         r_sinc;
  logic [N_DADOS-1:0] r_dados;
  logic [2:0]         r_nbits;
  logic               r_pbit;
  logic               r_erro_quadro;
  logic [N_DADOS-1:0] r_dado_recebido;
  logic               r_pronto;
  logic               r_tem_dado;
  logic               r_paridade_ok;
  logic               r_erro_stop;

  logic w_rx;
  logic w_limpa_cnt;
  logic w_tick_meio;
  logic w_tick_fim;
  logic w_fim_quadro;
  logic w_quadro_ruim;
  logic w_par_ok;
  logic w_aceita;
  logic w_carrega;

  assign w_rx = r_sinc[1];

  rx_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_limpa     (w_limpa_cnt),
    .o_tick_meio (w_tick_meio),
    .o_tick_fim  (w_tick_fim)
  );

  assign w_fim_quadro  = (r_estado == S_STOP2) && w_tick_fim;
  assign w_quadro_ruim = r_erro_quadro || !w_rx;
  assign w_par_ok      = (paridade_calc(r_dados, r_pbit) == 1'b0);
`ifdef RX_PARITY_CHECK_EN
  assign w_aceita      = w_par_ok;
`else
  assign w_aceita      = 1'b1;
`endif
  assign w_carrega     = w_fim_quadro && !w_quadro_ruim && w_aceita;

  always_comb begin
    w_prox      = r_estado;
    w_limpa_cnt = 1'b0;
    case (r_estado)
      S_IDLE: begin
        w_limpa_cnt = 1'b1;
        if (!w_rx) w_prox = S_START;
      end
      S_START: begin
        // A start bit that is high again at its centre was a glitch
        if (w_tick_meio) begin
          w_limpa_cnt = 1'b1;
          w_prox      = w_rx ? S_IDLE : S_DADOS;
        end
      end
      S_DADOS: begin
        if (w_tick_fim && (r_nbits == 3'(N_DADOS - 1))) w_prox = S_PARIDADE;
      end
      S_PARIDADE: begin
        if (w_tick_fim) w_prox = S_STOP1;
      end
      S_STOP1: begin
        if (w_tick_fim) w_prox = S_STOP2;
      end
      S_STOP2: begin
        if (w_tick_fim) w_prox = w_quadro_ruim ? S_ERRO : S_ARMAZENA;
      end
      S_ARMAZENA: w_prox = S_IDLE;
      S_ERRO: begin
        // Wait for the line to idle so a break does not look like a new start bit
        if (w_rx) w_prox = S_IDLE;
      end
      default: w_prox = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= S_IDLE;
      r_sinc   <= 2'b11;
    end else begin
      r_estado <= w_prox;
      r_sinc   <= {r_sinc[0], dado_serial};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dados       <= '0;
      r_nbits       <= '0;
      r_pbit        <= 1'b0;
      r_erro_quadro <= 1'b0;
    end else begin
      case (r_estado)
        S_IDLE: begin
          r_nbits       <= '0;
          r_erro_quadro <= 1'b0;
        end
        S_DADOS: begin
          if (w_tick_fim) begin
            r_dados <= {w_rx, r_dados[N_DADOS-1:1]};
            r_nbits <= r_nbits + 1'b1;
          end
        end
        S_PARIDADE: begin
          if (w_tick_fim) r_pbit <= w_rx;
        end
        S_STOP1: begin
          if (w_tick_fim && !w_rx) r_erro_quadro <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are registered on the STOP2 sample edge so pronto coincides with ARMAZENA
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dado_recebido <= '0;
      r_pronto        <= 1'b0;
      r_tem_dado      <= 1'b0;
      r_paridade_ok   <= 1'b0;
      r_erro_stop     <= 1'b0;
    end else begin
      r_pronto <= w_carrega;
      if (w_fim_quadro) begin
        r_paridade_ok <= w_par_ok;
        r_erro_stop   <= w_quadro_ruim;
      end
      if (w_carrega) r_dado_recebido <= r_dados;
      // A clear arriving alongside a new character loses to it
      if (w_carrega) begin
        r_tem_dado <= 1'b1;
      end else if (limpa && !r_pronto) begin
        r_tem_dado <= 1'b0;
      end
    end
  end

  assign dado_recebido = r_dado_recebido;
  assign pronto        = r_pronto;
  assign tem_dado      = r_tem_dado;
  assign paridade_ok   = r_paridade_ok;
  assign erro_stop     = r_erro_stop;
  assign db_estado     = r_estado;

endmodule
